low_band_fir: RTL

LOW_BAND_FIR -- requirements
Module: low_band_fir

---
 rtl/low_band_fir.sv | 123 ++++++++++++
 1 files changed

// File: rtl/low_band_fir.sv
// Streaming FIR: multiplies a burst of TAPS queue samples by ROM coefficients,
// accumulates, then emits one saturated Q1.15-scaled result per full burst.
module low_band_fir #(
  parameter int TAPS = 1021
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] smpl_in,
  input  logic               sequencing,
  input  logic signed [15:0] coeff_in,
  output logic [9:0]         coeff_addr,
  output logic signed [15:0] smpl_out,
  output logic               valid_out,
  output logic               short_seq,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [9:0] TAPS_C = 10'(TAPS);

  state_t             state, state_n;
  logic [9:0]         cnt, cnt_n;
  logic signed [41:0] acc, acc_n;
  logic signed [15:0] smpl_d, smpl_d_n;
  logic signed [15:0] out_n;
  logic               valid_n, short_n;
  logic               seq_d, armed, start;
  logic signed [31:0] prod;
  logic signed [41:0] sum, shifted;
  logic signed [15:0] sat_val;

  // armed blocks a false start when sequencing is already high at reset release
  assign start      = sequencing & ~seq_d & armed;
  assign coeff_addr = cnt;
  assign dbg_state  = state;

  // smpl_d and coeff_in are aligned: both belong to sample index cnt-1
  assign prod    = smpl_d * coeff_in;
  assign sum     = acc + {{10{prod[31]}}, prod};
  assign shifted = sum >>> 15;

  always_comb begin
    if (shifted > 42'sd32767)
      sat_val = 16'sh7FFF;
    else if (shifted < -42'sd32768)
      sat_val = 16'sh8000;
    else
      sat_val = shifted[15:0];
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    acc_n    = acc;
    smpl_d_n = smpl_d;
    out_n    = smpl_out;
    valid_n  = 1'b0;
    short_n  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = 10'd0;
        if (start) begin
          smpl_d_n = smpl_in;
          cnt_n    = 10'd1;
          acc_n    = '0;
          state_n  = (TAPS_C == 10'd1) ? FLUSH : ACCUM;
        end
      end
      ACCUM: begin
        acc_n = sum;
        if (!sequencing) begin
          state_n = IDLE;
          cnt_n   = 10'd0;
          short_n = 1'b1;
        end else if (cnt < TAPS_C) begin
          smpl_d_n = smpl_in;
          cnt_n    = cnt + 10'd1;
          if (cnt + 10'd1 == TAPS_C) state_n = FLUSH;
        end
      end
      FLUSH: begin
        out_n   = sat_val;
        valid_n = 1'b1;
        cnt_n   = 10'd0;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 10'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      smpl_d    <= '0;
      seq_d     <= 1'b0;
      armed     <= 1'b0;
      smpl_out  <= '0;
      valid_out <= 1'b0;
      short_seq <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      acc       <= acc_n;
      smpl_d    <= smpl_d_n;
      seq_d     <= sequencing;
      armed     <= armed | ~sequencing;
      smpl_out  <= out_n;
      valid_out <= valid_n;
      short_seq <= short_n;
    end
  end

endmodule
